mersenne_trial_ctrl: RTL and testbench

Requester-side controller for the modulo divider: given Mersenne exponent p and candidate factor q, it computes 2^p mod q by left-to-right square-and-double and reports whether q divides 2^p − 1. Every squaring is reduced by issuing one transaction to the divider (start/numerator/denominator out, remainder/finished in). Doublings are reduced locally. Sits between the candidate sequencer and the shared divider instance.

---
 rtl/mersenne_trial_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mersenne_trial_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mersenne_trial_ctrl.sv
// Mersenne trial-factor controller: computes 2^p mod q by square-and-double,
// offloading each squaring reduction to a shared modulo divider.
module mersenne_trial_ctrl (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] exponent,
  input  logic [15:0] candidate,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        is_factor,
  output logic        invalid,
  output logic        div_start,
  output logic [31:0] div_numerator,
  output logic [31:0] div_denominator,
  input  logic [31:0] div_remainder,
  input  logic        div_finished
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_SQ_REQ = 3'd2;
  localparam logic [2:0] S_SQ_GRD = 3'd3;
  localparam logic [2:0] S_SQ_WT  = 3'd4;
  localparam logic [2:0] S_DOUBLE = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] e_q, e_d;
  logic [15:0] q_q, q_d;
  logic [15:0] r_q, r_d;
  logic [5:0]  n_q, n_d;
  logic        job_inv_q, job_inv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        is_factor_q, is_factor_d;
  logic        invalid_q, invalid_d;

  logic        accept;
  logic [16:0] dbl;
  logic [16:0] dbl_sub;
  logic        unused_rem_hi;

  assign accept  = (state_q == S_IDLE) & start & ~done_q;
  assign dbl     = {r_q, 1'b0};
  assign dbl_sub = dbl - {1'b0, q_q};
  assign unused_rem_hi = ^div_remainder[31:16];

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    q_d         = q_q;
    r_d         = r_q;
    n_d         = n_q;
    job_inv_d   = job_inv_q;
    busy_d      = busy_q & ~done_q;
    done_d      = 1'b0;
    result_d    = result_q;
    is_factor_d = is_factor_q;
    invalid_d   = invalid_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          e_d         = exponent;
          q_d         = candidate;
          r_d         = 16'd1;
          n_d         = 6'd32;
          busy_d      = 1'b1;
          result_d    = 16'd0;
          is_factor_d = 1'b0;
          invalid_d   = 1'b0;
          job_inv_d   = (candidate < 16'd2);
          if (candidate < 16'd2) begin
            r_d     = 16'd0;
            state_d = S_FIN;
          end else if (exponent == 32'd0) begin
            state_d = S_FIN;
          end else if (exponent[31]) begin
            state_d = S_SQ_REQ;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        // Leading zero skipped; leave as soon as the next MSB is a one.
        e_d = {e_q[30:0], 1'b0};
        n_d = n_q - 6'd1;
        if (e_q[30]) begin
          state_d = S_SQ_REQ;
        end
      end
      S_SQ_REQ: state_d = S_SQ_GRD;
      S_SQ_GRD: state_d = S_SQ_WT;
      S_SQ_WT: begin
        if (div_finished) begin
          r_d     = div_remainder[15:0];
          state_d = S_DOUBLE;
        end
      end
      S_DOUBLE: begin
        if (e_q[31]) begin
          r_d = (dbl >= {1'b0, q_q}) ? dbl_sub[15:0] : dbl[15:0];
        end
        e_d = {e_q[30:0], 1'b0};
        n_d = n_q - 6'd1;
        state_d = (n_q == 6'd1) ? S_FIN : S_SQ_REQ;
      end
      S_FIN: begin
        result_d    = r_q;
        is_factor_d = (r_q == 16'd1) & ~job_inv_q;
        invalid_d   = job_inv_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      e_q         <= 32'd0;
      q_q         <= 16'd0;
      r_q         <= 16'd0;
      n_q         <= 6'd0;
      job_inv_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 16'd0;
      is_factor_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      q_q         <= q_d;
      r_q         <= r_d;
      n_q         <= n_d;
      job_inv_q   <= job_inv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      is_factor_q <= is_factor_d;
      invalid_q   <= invalid_d;
    end
  end

  // r only changes on capture or doubling, so the operands hold steady
  // for the whole divider transaction.
  assign div_start       = (state_q == S_SQ_REQ);
  assign div_numerator   = {16'd0, r_q} * {16'd0, r_q};
  assign div_denominator = {16'd0, q_q};

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign is_factor = is_factor_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_mersenne_trial_ctrl.sv
// Bench for mersenne_trial_ctrl: directed job table against a divider stub,
// plus reset-during-transaction and mid-job start sequences.
module tb_mersenne_trial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] exponent = 32'd0;
  logic [15:0] candidate = 16'd0;
  logic        busy, done, is_factor, invalid, div_start;
  logic [15:0] result;
  logic [31:0] div_numerator, div_denominator;
  logic [31:0] rem = 32'd0;
  logic        fin = 1'b0;

  always #5 clk = ~clk;

  mersenne_trial_ctrl dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .start          (start),
    .exponent       (exponent),
    .candidate      (candidate),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .is_factor      (is_factor),
    .invalid        (invalid),
    .div_start      (div_start),
    .div_numerator  (div_numerator),
    .div_denominator(div_denominator),
    .div_remainder  (rem),
    .div_finished   (fin)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider stub: latency lat_cfg (0 = random 1..20); sticky keeps a stale
  // finished with a bogus remainder through the guard cycle.
  int          lat_cfg = 4;
  bit          sticky_cfg = 1'b0;
  int          cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] snap_num = 32'd0;
  logic [31:0] snap_den = 32'd1;
  int          stab_err = 0;

  always @(posedge clk) begin
    if (div_start) begin
      cnt      <= (lat_cfg == 0) ? int'($urandom_range(1, 20)) : lat_cfg;
      fin      <= sticky_cfg;
      if (sticky_cfg) rem <= 32'h5a5a7777;
      snap_num <= div_numerator;
      snap_den <= div_denominator;
      pend     <= 1'b1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      fin <= (cnt == 1);
      if (cnt == 1) rem <= {16'ha5a5, 16'(snap_num % snap_den)};
    end else if (pend && fin) begin
      pend <= 1'b0;
    end
  end

  function automatic int unsigned pow2mod(input int unsigned k,
                                          input int unsigned m);
    int unsigned r;
    r = 1 % m;
    for (int unsigned i = 0; i < k; i++) r = (r * 2) % m;
    return r;
  endfunction

  function automatic int exp_cycles(input logic [31:0] p,
                                    input logic [15:0] q, input int lat);
    int lz;
    lz = 0;
    if (q < 16'd2 || p == 32'd0) return 2;
    for (int i = 31; i >= 0; i--) begin
      if (p[i]) break;
      lz++;
    end
    return lz + (32 - lz) * (3 + lat) + 2;
  endfunction

  typedef struct {
    logic [31:0] p;
    logic [15:0] q;
    int          lat;
    bit          sticky;
    bit          mid;
    logic [15:0] res;
    bit          fac;
    bit          inv;
    int          starts;
  } vec_t;

  vec_t v[13];

  task automatic run_job(input vec_t t, input int id);
    int  cyc, nstart, b2b, s0;
    bit  prev, got;
    lat_cfg    = t.lat;
    sticky_cfg = t.sticky;
    s0 = stab_err;
    @(negedge clk);
    start = 1'b1;
    exponent = t.p;
    candidate = t.q;
    @(negedge clk);
    if (t.mid) begin
      exponent = 32'd5;
      candidate = 16'd3;
    end else begin
      start = 1'b0;
    end
    chk($sformatf("v%0d busy_after_accept", id), busy, 1);
    cyc = 1; nstart = 0; b2b = 0; prev = 1'b0; got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (div_start) begin
        nstart++;
        if (prev) b2b++;
      end
      prev = div_start;
      if (pend && (div_numerator !== snap_num ||
                   div_denominator !== snap_den)) stab_err++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL v%0d timeout: no done after %0d cycles", id, cyc);
    end
    chk($sformatf("v%0d result", id), result, t.res);
    chk($sformatf("v%0d is_factor", id), is_factor, t.fac);
    chk($sformatf("v%0d invalid", id), invalid, t.inv);
    chk($sformatf("v%0d div_starts", id), nstart, t.starts);
    chk($sformatf("v%0d back_to_back", id), b2b, 0);
    chk($sformatf("v%0d operand_stable", id), stab_err - s0, 0);
    chk($sformatf("v%0d busy_at_done", id), busy, 1);
    if (t.lat != 0)
      chk($sformatf("v%0d cycles", id), cyc, exp_cycles(t.p, t.q, t.lat));
    @(negedge clk);
    chk($sformatf("v%0d busy_done_low", id), {busy, done}, 0);
  endtask

  initial begin
    int unsigned big_res;
    big_res = pow2mod(pow2mod(31, 65520), 65521);
    v[0]  = '{32'd11, 16'd23, 4, 0, 0, 16'd1, 1, 0, 4};
    v[1]  = '{32'd11, 16'd7, 3, 0, 0, 16'd4, 0, 0, 4};
    v[2]  = '{32'd29, 16'd233, 1, 0, 0, 16'd1, 1, 0, 5};
    v[3]  = '{32'd11, 16'd1, 2, 0, 0, 16'd0, 0, 1, 0};
    v[4]  = '{32'h12345, 16'd0, 2, 0, 0, 16'd0, 0, 1, 0};
    v[5]  = '{32'd0, 16'd5, 2, 0, 0, 16'd1, 1, 0, 0};
    v[6]  = '{32'h80000000, 16'd65521, 2, 0, 0, 16'(big_res), big_res == 1,
              0, 32};
    v[7]  = '{32'd29, 16'd233, 0, 1, 1, 16'd1, 1, 0, 5};
    v[8]  = '{32'd11, 16'd7, 0, 1, 1, 16'd4, 0, 0, 4};
    v[9]  = '{32'd2, 16'd3, 1, 1, 0, 16'd1, 1, 0, 2};
    v[10] = '{32'd1, 16'd3, 5, 0, 0, 16'd2, 0, 0, 1};
    v[11] = '{32'hFFFFFFFF, 16'd3, 1, 1, 0, 16'd2, 0, 0, 32};
    v[12] = '{32'd5, 16'd31, 0, 0, 1, 16'd1, 1, 0, 3};

    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, div_start, is_factor, invalid, result}, 0);
    chk("reset_operands", div_numerator | div_denominator, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) run_job(v[i], i);

    // Reset while a long divider transaction is outstanding.
    lat_cfg = 20;
    sticky_cfg = 1'b0;
    @(negedge clk);
    start = 1'b1;
    exponent = 32'd11;
    candidate = 16'd23;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !pend; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midwait_reset_outs",
        {busy, done, div_start, is_factor, invalid, result}, 0);
    chk("midwait_reset_operands", div_numerator | div_denominator, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", {busy, done, div_start}, 0);
    run_job(v[0], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
